inst_fetch_ctrl: RTL and testbench
==================================

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hbfc00000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  combined div/divu/axi/hazard block; suppresses new fetch requests.
REQ-005 SHALL have port redirect  input  1  one-cycle branch/exception redirect pulse.
REQ-006 SHALL have port redirect_pc  input  32  redirect target, valid with redirect.
REQ-007 SHALL have port inst_sram_req  output  1  fetch request.
REQ-008 SHALL have port inst_sram_addr  output  32  fetch address; equals internal pc.
REQ-009 SHALL have port inst_sram_addr_ok  input  1  request accepted this cycle.
REQ-010 SHALL have port inst_sram_data_ok  input  1  read data returned this cycle.
REQ-011 SHALL have port inst_sram_rdata  input  32  returned instruction.
REQ-012 SHALL have port out_allowin  input  1  downstream stage accepts this cycle.
REQ-013 SHALL have port out_valid  output  1  instruction presented downstream.
REQ-014 SHALL have port out_pc  output  32  pc of presented instruction.
REQ-015 SHALL have port out_inst  output  32  presented instruction.

Function
REQ-016 SHALL implement states IDLE, REQ, WAIT, HOLD plus a 1-bit cancel flag, a 32-bit pc register and a 32-bit instruction buffer.
REQ-017 SHALL allow at most one outstanding request at any time.
REQ-018 SHALL drive inst_sram_req = (state==REQ) & !stall; inst_sram_addr = pc in every state.
REQ-019 IDLE SHALL go to REQ unconditionally on the next clock.
REQ-020 REQ: req & addr_ok SHALL go to WAIT; stall held SHALL remain in REQ with req low and pc unchanged.
REQ-021 REQ: redirect without addr_ok SHALL load pc<=redirect_pc and stay in REQ (address may change before acceptance).
REQ-022 REQ: redirect together with addr_ok SHALL go to WAIT with cancel<=1 and pc<=redirect_pc.
REQ-023 WAIT: data_ok with cancel=0 SHALL present the data combinationally: out_valid=1, out_inst=rdata, out_pc=pc.
REQ-024 WAIT: data_ok, cancel=0, out_allowin=1 SHALL go to REQ with pc<=pc+4 (zero-bubble hand-off).
REQ-025 WAIT: data_ok, cancel=0, out_allowin=0 SHALL latch rdata into buffer and go to HOLD.
REQ-026 WAIT: data_ok with cancel=1 SHALL discard data, clear cancel, keep out_valid=0 and go to REQ (pc already holds target).
REQ-027 WAIT: redirect without data_ok SHALL set cancel<=1 and load pc<=redirect_pc; repeated redirects SHALL overwrite pc and keep cancel=1.
REQ-028 WAIT: redirect together with data_ok SHALL discard data, clear cancel, load pc<=redirect_pc, go to REQ, out_valid=0.
REQ-029 HOLD: out_valid=1, out_inst=buffer, out_pc=pc; out_allowin SHALL go to REQ with pc<=pc+4.
REQ-030 HOLD: redirect SHALL take priority over out_allowin: buffer dropped, out_valid forced 0 that cycle, pc<=redirect_pc, go to REQ.
REQ-031 redirect in IDLE SHALL load pc<=redirect_pc and go to REQ.
REQ-032 pc+4 SHALL wrap modulo 2^32 (32'hfffffffc -> 32'h00000000).
REQ-033 data_ok in IDLE, REQ or HOLD SHALL be ignored and leave state unchanged.
REQ-034 stall SHALL NOT affect WAIT or HOLD behaviour nor out_valid.

Reset
REQ-035 While reset is high: state=IDLE, cancel=0, pc=RESET_PC, buffer=0, inst_sram_req=0, out_valid=0, independent of clk.
REQ-036 Reset asserted mid-transaction SHALL abandon the outstanding request; first req after release SHALL carry RESET_PC.

Verification
REQ-037 Release reset, addr_ok/data_ok each one cycle later, out_allowin=1 -> req at 0xbfc00000, then 0xbfc00004, out_valid each data_ok cycle with matching out_pc.
REQ-038 data_ok at pc 0xbfc00008 with out_allowin=0 for 3 cycles -> out_valid held 4 cycles, out_inst stable, req low until hand-off, next req 0xbfc0000c.
REQ-039 redirect to 0x80001000 while WAIT, data_ok two cycles later -> that data never presented, next req at 0x80001000.
REQ-040 redirect to 0x80002000 in HOLD with out_allowin=1 same cycle -> out_valid=0 that cycle, next req 0x80002000.
REQ-041 stall=1 for 5 cycles in REQ -> req low, addr constant; stall drop -> req high same cycle.
REQ-042 reset pulsed while WAIT -> out_valid=0 and req=0 immediately; after release req at 0xbfc00000, stale data_ok while IDLE ignored.

Source files
------------

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction SRAM request/response channel plus the
// downstream valid/allowin hand-off.
//   master : the fetch controller (drives req/addr and the out_* presentation)
//   slave  : the SRAM + decode stage side
interface inst_fetch_ctrl_if;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        out_allowin;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  modport master (
    output inst_sram_req, inst_sram_addr, out_valid, out_pc, out_inst,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, out_allowin
  );

  modport slave (
    input  inst_sram_req, inst_sram_addr, out_valid, out_pc, out_inst,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, out_allowin
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller. Issues one SRAM read at a time at pc, hands
// the returned instruction to the next stage (zero-bubble when it accepts
// immediately, otherwise parked in a one-entry buffer) and squashes in-flight
// fetches when a redirect arrives.
// Ports:
//   clk, reset        clock, async active-high reset
//   stall             blocks issuing a new request
//   redirect/_pc      one-cycle branch/exception redirect and its target
//   bus (master)      SRAM req/addr/addr_ok/data_ok/rdata, out_valid/pc/inst,
//                     out_allowin
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  inst_fetch_ctrl_if.master    bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state, state_nx;
  logic        cancel, cancel_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] inst_buf, inst_buf_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cancel   <= 1'b0;
      pc       <= RESET_PC;
      inst_buf <= 32'h0;
    end else begin
      state    <= state_nx;
      cancel   <= cancel_nx;
      pc       <= pc_nx;
      inst_buf <= inst_buf_nx;
    end
  end

  always_comb begin
    state_nx           = state;
    cancel_nx          = cancel;
    pc_nx              = pc;
    inst_buf_nx        = inst_buf;
    bus.inst_sram_req  = (state == REQ) && !stall;
    bus.inst_sram_addr = pc;
    bus.out_valid      = 1'b0;
    bus.out_pc         = pc;
    bus.out_inst       = inst_buf;

    case (state)
      IDLE: begin
        state_nx = REQ;
        if (redirect) pc_nx = redirect_pc;
      end
      REQ: begin
        if (bus.inst_sram_req && bus.inst_sram_addr_ok) begin
          state_nx = WAIT;
          // accepted at the old address: the response must be thrown away
          if (redirect) begin
            cancel_nx = 1'b1;
            pc_nx     = redirect_pc;
          end
        end else if (redirect) begin
          pc_nx = redirect_pc;
        end
      end
      WAIT: begin
        if (bus.inst_sram_data_ok) begin
          state_nx  = REQ;
          cancel_nx = 1'b0;
          if (redirect) begin
            pc_nx = redirect_pc;
          end else if (!cancel) begin
            bus.out_valid = 1'b1;
            bus.out_inst  = bus.inst_sram_rdata;
            if (bus.out_allowin) begin
              pc_nx = pc + 32'd4;
            end else begin
              inst_buf_nx = bus.inst_sram_rdata;
              state_nx    = HOLD;
            end
          end
        end else if (redirect) begin
          // pc already moves to the target; the eventual response is stale
          cancel_nx = 1'b1;
          pc_nx     = redirect_pc;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nx    = redirect_pc;
          state_nx = REQ;
        end else begin
          bus.out_valid = 1'b1;
          if (bus.out_allowin) begin
            pc_nx    = pc + 32'd4;
            state_nx = REQ;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;
  localparam logic [31:0] RPC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  int          n_chk = 0;
  int          n_fail = 0;

  inst_fetch_ctrl_if bus();

  inst_fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- transaction-level reference ----------------
  // fresh: first cycle out of reset (no request yet); outstanding: a read
  // was accepted and not yet answered; poison: that answer must be dropped;
  // have: an instruction is parked waiting for the next stage.
  logic        m_fresh, m_out, m_poison, m_have;
  logic [31:0] m_pc, m_buf;
  logic        e_req, e_valid, accept, retire;
  logic [31:0] e_inst;

  assign e_req   = !m_fresh && !m_out && !m_have && !stall;
  assign e_valid = m_have ? !redirect
                          : (m_out && bus.inst_sram_data_ok && !m_poison && !redirect);
  assign e_inst  = m_have ? m_buf : bus.inst_sram_rdata;
  assign accept  = e_req && bus.inst_sram_addr_ok;
  assign retire  = m_out && bus.inst_sram_data_ok;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_fresh <= 1'b1; m_out <= 1'b0; m_poison <= 1'b0; m_have <= 1'b0;
      m_pc <= RPC; m_buf <= 32'h0;
    end else begin
      m_fresh  <= 1'b0;
      m_have   <= m_have ? !(redirect || bus.out_allowin)
                         : (retire && e_valid && !bus.out_allowin);
      if (!m_have && retire && e_valid && !bus.out_allowin) m_buf <= bus.inst_sram_rdata;
      m_out    <= accept || (m_out && !bus.inst_sram_data_ok);
      m_poison <= accept ? redirect
                         : (m_out && !bus.inst_sram_data_ok && (m_poison || redirect));
      m_pc     <= redirect ? redirect_pc
                : (e_valid && bus.out_allowin) ? m_pc + 32'd4 : m_pc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // continuous compare against the reference
  always @(negedge clk) begin
    chk("req", {31'h0, bus.inst_sram_req}, {31'h0, e_req});
    chk("addr", bus.inst_sram_addr, m_pc);
    chk("out_valid", {31'h0, bus.out_valid}, {31'h0, e_valid});
    if (e_valid) begin
      chk("out_pc", bus.out_pc, m_pc);
      chk("out_inst", bus.out_inst, e_inst);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    stall = 0; redirect = 0;
    bus.inst_sram_addr_ok = 0; bus.inst_sram_data_ok = 0;
  endtask

  task automatic lit(input string nm, input logic req, input logic [31:0] addr);
    #1;
    chk({nm, "_req"}, {31'h0, bus.inst_sram_req}, {31'h0, req});
    chk({nm, "_addr"}, bus.inst_sram_addr, addr);
  endtask

  task automatic litv(input string nm, input logic v, input logic [31:0] pc,
                      input logic [31:0] inst);
    #1;
    chk({nm, "_valid"}, {31'h0, bus.out_valid}, {31'h0, v});
    if (v) begin
      chk({nm, "_pc"}, bus.out_pc, pc);
      chk({nm, "_inst"}, bus.out_inst, inst);
    end
  endtask

  initial begin
    bus.inst_sram_addr_ok = 0; bus.inst_sram_data_ok = 0;
    bus.inst_sram_rdata = 0; bus.out_allowin = 1;
    tick(); tick();
    lit("reset", 0, RPC);
    litv("reset", 0, 0, 0);
    reset = 0;
    // IDLE: stale data_ok ignored
    bus.inst_sram_data_ok = 1; litv("idle_stale", 0, 0, 0);
    tick(); clr();
    // basic fetch stream
    lit("first", 1, 32'hbfc00000);
    bus.inst_sram_addr_ok = 1; tick(); clr();
    bus.inst_sram_data_ok = 1; bus.inst_sram_rdata = 32'h11110000;
    litv("d0", 1, 32'hbfc00000, 32'h11110000);
    tick(); clr();
    lit("second", 1, 32'hbfc00004);
    bus.inst_sram_addr_ok = 1; tick(); clr();
    bus.inst_sram_data_ok = 1; bus.inst_sram_rdata = 32'h22220000;
    litv("d1", 1, 32'hbfc00004, 32'h22220000);
    tick(); clr();
    // backpressure: allowin low 3 cycles
    bus.inst_sram_addr_ok = 1; tick(); clr();
    bus.inst_sram_data_ok = 1; bus.inst_sram_rdata = 32'h33330000; bus.out_allowin = 0;
    litv("hold0", 1, 32'hbfc00008, 32'h33330000);
    tick(); clr(); bus.inst_sram_rdata = 32'hdeadbeef;
    litv("hold1", 1, 32'hbfc00008, 32'h33330000); lit("hold1", 0, 32'hbfc00008);
    tick();
    litv("hold2", 1, 32'hbfc00008, 32'h33330000);
    tick(); bus.out_allowin = 1;
    litv("hold3", 1, 32'hbfc00008, 32'h33330000);
    tick();
    lit("after_hold", 1, 32'hbfc0000c);
    // redirect while waiting
    bus.inst_sram_addr_ok = 1; tick(); clr();
    redirect = 1; redirect_pc = 32'h80001000; tick(); clr();
    tick();
    bus.inst_sram_data_ok = 1; bus.inst_sram_rdata = 32'h44440000;
    litv("cancelled", 0, 0, 0);
    tick(); clr();
    lit("redir_wait", 1, 32'h80001000);
    // redirect in HOLD beats allowin
    bus.inst_sram_addr_ok = 1; tick(); clr();
    bus.inst_sram_data_ok = 1; bus.inst_sram_rdata = 32'h55550000; bus.out_allowin = 0;
    tick(); clr();
    redirect = 1; redirect_pc = 32'h80002000; bus.out_allowin = 1;
    litv("redir_hold", 0, 0, 0);
    tick(); clr();
    lit("redir_hold", 1, 32'h80002000);
    // stall in REQ
    stall = 1; bus.inst_sram_addr_ok = 1;
    for (int i = 0; i < 5; i++) begin
      lit("stall", 0, 32'h80002000);
      tick();
    end
    stall = 0;
    lit("unstall", 1, 32'h80002000);
    tick(); clr();
    // reset while waiting
    bus.inst_sram_data_ok = 1; bus.inst_sram_rdata = 32'h66660000; reset = 1;
    litv("rst_wait", 0, 0, 0); lit("rst_wait", 0, RPC);
    tick(); reset = 0;
    litv("rst_stale", 0, 0, 0);
    tick(); clr();
    lit("rst_after", 1, 32'hbfc00000);
    // redirect in REQ without acceptance, then with acceptance; pc wrap
    redirect = 1; redirect_pc = 32'hfffffff8; tick(); clr();
    lit("req_redir", 1, 32'hfffffff8);
    bus.inst_sram_addr_ok = 1; redirect = 1; redirect_pc = 32'hfffffffc; tick(); clr();
    bus.inst_sram_data_ok = 1; bus.inst_sram_rdata = 32'h77770000;
    litv("acc_redir_drop", 0, 0, 0);
    tick(); clr();
    lit("acc_redir", 1, 32'hfffffffc);
    bus.inst_sram_addr_ok = 1; tick(); clr();
    bus.inst_sram_data_ok = 1; bus.inst_sram_rdata = 32'h88880000;
    litv("wrap_data", 1, 32'hfffffffc, 32'h88880000);
    tick(); clr();
    lit("wrap", 1, 32'h00000000);
    // redirect together with data_ok
    bus.inst_sram_addr_ok = 1; tick(); clr();
    bus.inst_sram_data_ok = 1; redirect = 1; redirect_pc = 32'h12345678;
    litv("redir_data", 0, 0, 0);
    tick(); clr();
    lit("redir_data", 1, 32'h12345678);
    // redirect in IDLE
    reset = 1; tick(); reset = 0;
    redirect = 1; redirect_pc = 32'h00000040; tick(); clr();
    lit("idle_redir", 1, 32'h00000040);
    // randomized traffic, compared every cycle by the reference
    for (int i = 0; i < 400; i++) begin
      stall                 = ($urandom % 4) == 0;
      redirect              = ($urandom % 8) == 0;
      redirect_pc           = $urandom & 32'hfffffffc;
      bus.inst_sram_addr_ok = $urandom % 2;
      bus.inst_sram_data_ok = m_out && ($urandom % 2);
      bus.inst_sram_rdata   = $urandom;
      bus.out_allowin       = $urandom % 2;
      tick();
    end
    clr();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
